// File: rtl/control_multiciclo.sv
// Multicycle MIPS-subset control unit: Moore FSM sequencing fetch/decode/execute
// with a sticky illegal-instruction flag and overflow write suppression.
module control_multiciclo (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic [3:0] alu_control,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC_R  = 4'd6,
    ALUWB_R = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    EXEC_I  = 4'd10,
    ALUWB_I = 4'd11
  } state_t;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_LUI  = 4'b0101;
  localparam logic [3:0] ALU_BGEZ = 4'b1111;
  localparam logic [3:0] ALU_BNE  = 4'b1010;

  localparam logic [5:0] OP_R      = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  state_t     cur;
  state_t     nxt;
  logic       ovf_q;
  logic       illegal_q;
  logic [3:0] r_alu;
  logic [3:0] i_alu;
  logic [3:0] b_alu;
  logic       funct_ok;
  logic       opcode_ok;

  always_comb begin
    r_alu    = ALU_ADD;
    funct_ok = 1'b1;
    case (funct)
      6'b100000: r_alu = ALU_ADD;
      6'b100010: r_alu = ALU_SUB;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b100111: r_alu = ALU_NOR;
      6'b101010: r_alu = ALU_SLT;
      default:   funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    i_alu = ALU_ADD;
    case (opcode)
      OP_ANDI: i_alu = ALU_AND;
      OP_ORI:  i_alu = ALU_OR;
      OP_SLTI: i_alu = ALU_SLT;
      OP_LUI:  i_alu = ALU_LUI;
      default: i_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    b_alu = ALU_SUB;
    case (opcode)
      OP_BNE:    b_alu = ALU_BNE;
      OP_REGIMM: b_alu = ALU_BGEZ;
      default:   b_alu = ALU_SUB;
    endcase
  end

  always_comb begin
    nxt       = FETCH;
    opcode_ok = 1'b1;
    case (cur)
      FETCH:  nxt = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW:                          nxt = MEMADR;
          OP_R:                                  nxt = EXEC_R;
          OP_BEQ, OP_BNE, OP_REGIMM:             nxt = BRANCH;
          OP_J:                                  nxt = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI,
          OP_LUI:                                nxt = EXEC_I;
          default: begin
            nxt       = FETCH;
            opcode_ok = 1'b0;
          end
        endcase
      end
      MEMADR:  nxt = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   nxt = MEMWB;
      EXEC_R:  nxt = ALUWB_R;
      EXEC_I:  nxt = ALUWB_I;
      default: nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur       <= FETCH;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      cur <= nxt;
      if ((cur == DECODE && !opcode_ok) || (cur == EXEC_R && !funct_ok))
        illegal_q <= 1'b1;
      // Only an ADD can suppress the writeback; any other EXEC op clears it.
      if (cur == EXEC_R)
        ovf_q <= overflow && (r_alu == ALU_ADD);
      else if (cur == EXEC_I)
        ovf_q <= overflow && (i_alu == ALU_ADD);
    end
  end

  always_comb begin
    alu_control = 4'b0000;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_write    = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    pc_source   = 2'b00;
    case (cur)
      FETCH: begin
        mem_read    = 1'b1;
        ir_write    = 1'b1;
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        pc_write    = 1'b1;
      end
      DECODE: begin
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
      end
      MEMADR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      EXEC_R: begin
        alu_src_a   = 1'b1;
        alu_control = r_alu;
      end
      ALUWB_R: begin
        reg_write = !ovf_q;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = b_alu;
        pc_source   = 2'b01;
        pc_write    = zero;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      EXEC_I: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = i_alu;
      end
      ALUWB_I: reg_write = !ovf_q;
      default: ;
    endcase
  end

  assign state   = cur;
  assign illegal = illegal_q;

endmodule

// File: doc/control_multiciclo.md
CONTROL_MULTICICLO -- requirements
Module: control_multiciclo

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes happen on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port opcode, input, 6, instruction bits [31:26] from the instruction register.
REQ-004 SHALL have port funct, input, 6, instruction bits [5:0].
REQ-005 SHALL have port zero, input, 1, ALU zero flag (combinational in the same cycle).
REQ-006 SHALL have port overflow, input, 1, ALU overflow flag (combinational in the same cycle).
REQ-007 SHALL have port alu_control, output, 4, ALU operation code.
REQ-008 SHALL have port alu_src_a, output, 1, ALU operand A select: 0 = PC, 1 = rs.
REQ-009 SHALL have port alu_src_b, output, 2, ALU operand B select: 00 = rt, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate<<2.
REQ-010 SHALL have ports pc_write, iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, each output, 1, datapath enables/selects.
REQ-011 SHALL have port pc_source, output, 2, PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-012 SHALL have port state, output, 4, current FSM state encoding.
REQ-013 SHALL have port illegal, output, 1, sticky unsupported-opcode flag.

Function
REQ-014 SHALL use these ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, LUI 0101, BGEZ 1111, BNE 1010.
REQ-015 SHALL implement states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, ALUWB_R=7, BRANCH=8, JUMP=9, EXEC_I=10, ALUWB_I=11.
REQ-016 SHALL drive all outputs as a Moore function of state only, except pc_write in BRANCH, which also depends on zero; outputs not listed for a state SHALL be 0.
REQ-017 FETCH SHALL assert mem_read and ir_write, set iord=0, alu_src_a=0, alu_src_b=01, alu_control=ADD, pc_source=00, assert pc_write, and go to DECODE.
REQ-018 DECODE SHALL set alu_src_a=0, alu_src_b=11, alu_control=ADD to compute the branch target, then dispatch on opcode.
REQ-019 DECODE dispatch SHALL be: 100011/101011 -> MEMADR; 000000 -> EXEC_R; 000100/000101/000001 -> BRANCH; 000010 -> JUMP; 001000/001100/001101/001010/001111 -> EXEC_I.
REQ-020 Any other opcode in DECODE SHALL set illegal=1 and return to FETCH.
REQ-021 MEMADR SHALL set alu_src_a=1, alu_src_b=10, alu_control=ADD, then go to MEMRD for opcode 100011 or MEMWR for 101011.
REQ-022 MEMRD SHALL assert mem_read with iord=1 and go to MEMWB.
REQ-023 MEMWB SHALL assert reg_write with mem_to_reg=1 and reg_dst=0, then go to FETCH.
REQ-024 MEMWR SHALL assert mem_write with iord=1, then go to FETCH.
REQ-025 EXEC_R SHALL set alu_src_a=1, alu_src_b=00, and map funct 100000->ADD, 100010->SUB, 100100->AND, 100101->OR, 100111->NOR, 101010->SLT; any other funct SHALL give ADD and set illegal.
REQ-026 EXEC_I SHALL set alu_src_a=1, alu_src_b=10, and map opcode 001000->ADD, 001100->AND, 001101->OR, 001010->SLT, 001111->LUI.
REQ-027 In EXEC_R and EXEC_I, overflow=1 with an ADD operation SHALL be latched into an internal ovf_q, and ovf_q SHALL be cleared in every other EXEC cycle.
REQ-028 EXEC_R SHALL go to ALUWB_R and EXEC_I SHALL go to ALUWB_I.
REQ-029 ALUWB_R/ALUWB_I SHALL assert reg_write (reg_dst 1/0, mem_to_reg=0) only when ovf_q=0, then go to FETCH.
REQ-030 BRANCH SHALL set alu_src_a=1, pc_source=01, and alu_control=SUB (beq, alu_src_b=00), BNE (bne, alu_src_b=00), or BGEZ (regimm), and assert pc_write iff zero=1; it SHALL then go to FETCH.
REQ-031 JUMP SHALL assert pc_write with pc_source=10, then go to FETCH.
REQ-032 Instruction latency SHALL be: lw 5 cycles; sw, R-type, I-type 4; branch, jump 3.

Reset
REQ-033 On reset=1, at any time including mid-instruction, state SHALL become FETCH, and ovf_q and illegal SHALL become 0.
REQ-034 All outputs SHALL show FETCH values while reset is held; the first FETCH SHALL start on the first clock after reset falls.
REQ-035 illegal SHALL clear only on reset.

Verification
REQ-036 lw (opcode 100011): states 0,1,2,3,4,0; reg_write=1 with mem_to_reg=1 only in state 4.
REQ-037 R-type sub (funct 100010): alu_control=0110 in state 6; reg_write=1 with reg_dst=1 in state 7.
REQ-038 beq with zero=1 -> pc_write=1, pc_source=01 in state 8; with zero=0 -> pc_write=0.
REQ-039 addi with overflow=1 in state 10 -> reg_write=0 in state 11; the next add with overflow=0 writes normally.
REQ-040 opcode 111111 -> illegal=1, states 0,1,0; reset asserted in state 3 -> state=0 asynchronously and illegal=0.
